// File: rtl/uart_cmd.sv
// Byte-stream command decoder: opcode byte (MSB selects short/long), then AN argument
// bytes for long opcodes, emitted as one command word with an inter-byte timeout.
module uart_cmd #(
  parameter int DW = 8,
  parameter int AN = 4,
  parameter int TN = 65536,
  parameter int TL = $clog2(TN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             str_tvalid,
  input  logic [DW-1:0]    str_tdata,
  output logic             str_tready,
  output logic             cmd_tvalid,
  input  logic             cmd_tready,
  output logic [DW-1:0]    cmd_code,
  output logic [AN*DW-1:0] cmd_data,
  output logic             cmd_long,
  output logic             err_tmo
);

  localparam int            CW       = (AN > 1) ? $clog2(AN) : 1;
  localparam logic [TL-1:0] TMO_LOAD = TL'(TN - 1);
  localparam logic [CW-1:0] ARG_LAST = CW'(AN - 1);

  typedef enum logic [1:0] {IDLE, ARG, OUT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] arg_cnt;
  logic [TL-1:0] tmo_cnt;
  logic          byte_xfer;
  logic          tmo_hit;

  assign byte_xfer = str_tvalid && str_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Handshake outputs depend only on state, so no str_tdata -> cmd_* path exists.
  always_comb begin
    state_nxt  = state;
    str_tready = 1'b0;
    cmd_tvalid = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        str_tready = 1'b1;
        if (str_tvalid) state_nxt = str_tdata[DW-1] ? ARG : OUT;
      end
      ARG: begin
        str_tready = 1'b1;
        if (str_tvalid) begin
          if (arg_cnt == ARG_LAST) state_nxt = OUT;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      OUT: begin
        cmd_tvalid = 1'b1;
        if (cmd_tready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_code <= '0;
      cmd_data <= '0;
      cmd_long <= 1'b0;
      arg_cnt  <= '0;
      tmo_cnt  <= TMO_LOAD;
      err_tmo  <= 1'b0;
    end else begin
      err_tmo <= tmo_hit;

      // A byte on the same edge as an expiring count wins: reload beats timeout.
      if (byte_xfer)
        tmo_cnt <= TMO_LOAD;
      else if (state == ARG && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - TL'(1);

      if (tmo_hit) cmd_data <= '0;

      if (byte_xfer) begin
        case (state)
          IDLE: begin
            cmd_code <= str_tdata;
            cmd_data <= '0;
            cmd_long <= str_tdata[DW-1];
            arg_cnt  <= '0;
          end
          ARG: begin
            cmd_data[arg_cnt*DW +: DW] <= str_tdata;
            arg_cnt                    <= arg_cnt + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd.sv
// Directed bench for uart_cmd (TN=8): short/long decode, back-pressure, timeout,
// byte-at-expiry, and reset in the middle of a command.
module tb_uart_cmd;

  localparam int DW = 8;
  localparam int AN = 4;
  localparam int TN = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             str_tvalid = 1'b0;
  logic [DW-1:0]    str_tdata = '0;
  logic             str_tready;
  logic             cmd_tvalid;
  logic             cmd_tready = 1'b0;
  logic [DW-1:0]    cmd_code;
  logic [AN*DW-1:0] cmd_data;
  logic             cmd_long;
  logic             err_tmo;

  int n_chk = 0;
  int n_err = 0;

  uart_cmd #(.DW(DW), .AN(AN), .TN(TN)) dut (
    .clk(clk), .rst(rst),
    .str_tvalid(str_tvalid), .str_tdata(str_tdata), .str_tready(str_tready),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .cmd_long(cmd_long),
    .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [DW-1:0] b);
    int n = 0;
    str_tvalid = 1'b1;
    str_tdata  = b;
    while (!str_tready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("send_stall", 64'(n), 64'(0));
    @(posedge clk); #1;
    str_tvalid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #3;
    chk("rst_tvalid", 64'(cmd_tvalid), 64'd0);
    chk("rst_err", 64'(err_tmo), 64'd0);
    chk("rst_code", 64'(cmd_code), 64'd0);
    chk("rst_data", 64'(cmd_data), 64'd0);
    chk("rst_long", 64'(cmd_long), 64'd0);
    #10 rst = 1'b1;
    step();
    chk("rel_tready", 64'(str_tready), 64'd1);

    // short command
    cmd_tready = 1'b1;
    send(8'h01);
    chk("s_tvalid", 64'(cmd_tvalid), 64'd1);
    chk("s_code", 64'(cmd_code), 64'h01);
    chk("s_long", 64'(cmd_long), 64'd0);
    chk("s_data", 64'(cmd_data), 64'h0);
    step();
    chk("s_done", 64'(cmd_tvalid), 64'd0);
    chk("s_idle", 64'(str_tready), 64'd1);

    // long command, one tvalid only after last argument
    cmd_tready = 1'b0;
    send(8'h80); chk("l_tv0", 64'(cmd_tvalid), 64'd0);
    send(8'h11); chk("l_tv1", 64'(cmd_tvalid), 64'd0);
    send(8'h22); chk("l_tv2", 64'(cmd_tvalid), 64'd0);
    send(8'h33); chk("l_tv3", 64'(cmd_tvalid), 64'd0);
    send(8'h44);
    chk("l_tvalid", 64'(cmd_tvalid), 64'd1);
    chk("l_code", 64'(cmd_code), 64'h80);
    chk("l_long", 64'(cmd_long), 64'd1);
    chk("l_data", 64'(cmd_data), 64'h44332211);
    cmd_tready = 1'b1;
    step();
    chk("l_done", 64'(cmd_tvalid), 64'd0);

    // back-pressure
    cmd_tready = 1'b0;
    send(8'h02);
    str_tvalid = 1'b1;
    str_tdata  = 8'h03;
    for (int i = 0; i < 10; i++) begin
      chk("bp_tready", 64'(str_tready), 64'd0);
      chk("bp_tvalid", 64'(cmd_tvalid), 64'd1);
      chk("bp_code", 64'(cmd_code), 64'h02);
      step();
    end
    cmd_tready = 1'b1;
    step();
    chk("bp_rel_tv", 64'(cmd_tvalid), 64'd0);
    chk("bp_rel_rdy", 64'(str_tready), 64'd1);
    step();
    str_tvalid = 1'b0;
    chk("bp2_tvalid", 64'(cmd_tvalid), 64'd1);
    chk("bp2_code", 64'(cmd_code), 64'h03);
    step();
    chk("bp2_done", 64'(cmd_tvalid), 64'd0);

    // timeout: err_tmo 8 cycles after the last byte
    send(8'hC0);
    send(8'hAA);
    for (int i = 1; i < 8; i++) begin
      chk("to_early", 64'(err_tmo), 64'd0);
      chk("to_tvalid", 64'(cmd_tvalid), 64'd0);
      step();
    end
    chk("to_early7", 64'(err_tmo), 64'd0);
    step();
    chk("to_pulse", 64'(err_tmo), 64'd1);
    chk("to_tv", 64'(cmd_tvalid), 64'd0);
    step();
    chk("to_end", 64'(err_tmo), 64'd0);
    chk("to_idle", 64'(str_tready), 64'd1);
    send(8'h05);
    chk("to_s_tv", 64'(cmd_tvalid), 64'd1);
    chk("to_s_code", 64'(cmd_code), 64'h05);
    chk("to_s_long", 64'(cmd_long), 64'd0);
    chk("to_s_data", 64'(cmd_data), 64'h0);
    step();

    // byte arriving exactly as the counter reaches 0
    send(8'hC1);
    send(8'hB0);
    for (int i = 0; i < 7; i++) begin
      chk("ex_wait", 64'(err_tmo), 64'd0);
      step();
    end
    send(8'hB1);
    chk("ex_noerr", 64'(err_tmo), 64'd0);
    send(8'hB2);
    chk("ex_noerr2", 64'(err_tmo), 64'd0);
    send(8'hB3);
    chk("ex_tvalid", 64'(cmd_tvalid), 64'd1);
    chk("ex_code", 64'(cmd_code), 64'hC1);
    chk("ex_long", 64'(cmd_long), 64'd1);
    chk("ex_data", 64'(cmd_data), 64'hB3B2B1B0);
    step();
    chk("ex_done", 64'(cmd_tvalid), 64'd0);

    // reset in ARG after two argument bytes
    cmd_tready = 1'b0;
    send(8'h85);
    send(8'h11);
    send(8'h22);
    rst = 1'b0;
    #2;
    chk("mr_tvalid", 64'(cmd_tvalid), 64'd0);
    chk("mr_code", 64'(cmd_code), 64'h0);
    chk("mr_data", 64'(cmd_data), 64'h0);
    chk("mr_long", 64'(cmd_long), 64'd0);
    chk("mr_err", 64'(err_tmo), 64'd0);
    chk("mr_tready", 64'(str_tready), 64'd1);
    #2 rst = 1'b1;
    step();
    send(8'h81);
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    chk("mr_tv_pre", 64'(cmd_tvalid), 64'd0);
    send(8'hA4);
    chk("mr2_tvalid", 64'(cmd_tvalid), 64'd1);
    chk("mr2_code", 64'(cmd_code), 64'h81);
    chk("mr2_long", 64'(cmd_long), 64'd1);
    chk("mr2_data", 64'(cmd_data), 64'hA4A3A2A1);
    cmd_tready = 1'b1;
    step();
    chk("mr2_done", 64'(cmd_tvalid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd.md
UART_CMD -- requirements
Module: uart_cmd

Interface
REQ-001 Parameter DW, default 8, byte width of the input stream.
REQ-002 Parameter AN, default 4, number of argument bytes that follow a long opcode.
REQ-003 Parameter TN, default 65536, idle clock periods allowed between argument bytes before the command is abandoned.
REQ-004 Parameter TL, default $clog2(TN), width of the timeout counter.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 str_tvalid  input  1  byte available from the receiver.
REQ-008 str_tdata  input  DW  received byte.
REQ-009 str_tready  output  1  block accepts the byte.
REQ-010 cmd_tvalid  output  1  decoded command available.
REQ-011 cmd_tready  input  1  consumer accepts the command.
REQ-012 cmd_code  output  DW  opcode byte.
REQ-013 cmd_data  output  AN*DW  argument word.
REQ-014 cmd_long  output  1  1 = long command (carries arguments); 0 = short command.
REQ-015 err_tmo  output  1  one-cycle pulse when an incomplete long command is abandoned.

Function
REQ-016 A byte transfer occurs when str_tvalid and str_tready are both 1 on a rising clk edge; a command transfer occurs when cmd_tvalid and cmd_tready are both 1.
REQ-017 FSM states: IDLE, ARG, OUT.
REQ-018 IDLE: str_tready=1, cmd_tvalid=0.
- Byte with MSB 0 (short opcode): latch cmd_code, clear cmd_data to 0, set cmd_long=0, go to OUT.
- Byte with MSB 1 (long opcode): latch cmd_code, clear cmd_data and the argument counter, set cmd_long=1, go to ARG.
REQ-019 ARG: str_tready=1, cmd_tvalid=0.
- Argument byte k (k=0..AN-1) is written to cmd_data[k*DW +: DW], so the first byte is least significant.
- The AN-th argument byte moves the FSM to OUT.
REQ-020 OUT: str_tready=0, cmd_tvalid=1; cmd_code, cmd_data and cmd_long hold stable until the command transfer, then the FSM returns to IDLE.
REQ-021 Latency: cmd_tvalid rises on the first clk edge after the final byte of the command is accepted (one cycle); no combinational path from str_tdata to any cmd_* output.
REQ-022 Timeout counter: loaded with TN-1 on every accepted byte in IDLE or ARG; decrements by 1 each cycle while in ARG without a byte transfer.
REQ-023 Counter reaching 0 in ARG without a byte transfer:
- FSM returns to IDLE;
- err_tmo=1 for exactly one cycle;
- no command is issued, and the partial cmd_data is discarded.
REQ-024 A byte transfer on the same cycle the counter reaches 0 takes priority; no timeout occurs.
REQ-025 Back-pressure: while in OUT, input bytes are stalled, not dropped; the upstream receiver holds them.
REQ-026 Opcode classification uses only bit DW-1 of the first byte; all other opcode values pass through unchanged.
REQ-027 The timeout counter does not run in IDLE or OUT; a stalled consumer never causes err_tmo.

Reset
REQ-028 While rst=0, regardless of clk:
- FSM=IDLE;
- cmd_tvalid=0, err_tmo=0, cmd_long=0, cmd_code=0, cmd_data=0;
- argument counter=0, timeout counter=TN-1.
REQ-029 Reset asserted mid-command (ARG or OUT) discards the command; after release the first accepted byte is treated as an opcode.
REQ-030 str_tready=1 in the first cycle after reset release.

Verification
REQ-031 Short command: byte 0x01 with cmd_tready=1 -> next cycle cmd_tvalid=1, cmd_code=0x01, cmd_long=0, cmd_data=0x00000000; IDLE after 1 cycle.
REQ-032 Long command: bytes 0x80,0x11,0x22,0x33,0x44 -> cmd_code=0x80, cmd_long=1, cmd_data=0x44332211; exactly one cmd_tvalid per command.
REQ-033 Back-pressure: short 0x02 then 0x03 with cmd_tready=0 for 10 cycles -> str_tready=0 and outputs hold 0x02 for 10 cycles; after release 0x02 then 0x03 are delivered in order, none lost.
REQ-034 Timeout (TN=8): 0xC0,0xAA then silence -> err_tmo pulses once 8 cycles after 0xAA, no cmd_tvalid; a following 0x05 decodes as a short command.
REQ-035 Byte arriving exactly when the counter hits 0 (TN=8) -> accepted as an argument, no err_tmo.
REQ-036 rst=0 pulse during ARG after 2 argument bytes -> all outputs reset; a subsequent 0x81 + 4 bytes decodes correctly.
